// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample streamer slice: widths, tap count, sample type, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a. FLUSH state only exists when FIR_SAMPLE_STREAMER_FLUSH_EN is defined.
package fir_pkg;

   localparam int DATA_W = 16;
   localparam int TAPS   = 123;

   typedef logic signed [DATA_W-1:0] sample_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
`ifdef FIR_SAMPLE_STREAMER_FLUSH_EN
      ST_FLUSH  = 2'd2,
`endif
      ST_STREAM = 2'd1
   } stream_state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous sample FIFO with occupancy count; head word is visible combinationally on rd_data.
// Latency: a write is visible at the head one cycle after it is accepted.
// Backpressure: writes while full are dropped (even with a same-cycle pop); pops while empty are ignored.
module fir_sync_fifo
#(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int DEPTH  = 64
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     rd_en,
   output logic signed [DATA_W-1:0] rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic signed [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]            r_wr_ptr;
   logic [AW-1:0]            r_rd_ptr;
   logic [CW-1:0]            r_count;
   logic                     w_push;
   logic                     w_pop;

   assign full    = (r_count == CW'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign rd_data = r_mem[r_rd_ptr];
   assign w_push  = wr_en & ~full;
   assign w_pop   = rd_en & ~empty;

   // Storage array: no reset needed, validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; count only moves on an unmatched push or pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fir_sample_streamer.sv
// Streams frame_len FIFO samples to a FIR input (plus TAPS-1 trailing zeros when FIR_SAMPLE_STREAMER_FLUSH_EN is defined).
// Latency: first beat valid two cycles after an accepted start when the FIFO already holds data.
// Backpressure: valid/ready output register; data and last hold while stalled; an empty FIFO mid-frame sets sticky underrun.
module fir_sample_streamer
#(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int DEPTH  = 64,
   parameter int TAPS   = fir_pkg::TAPS
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic signed [DATA_W-1:0] wr_data,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     start,
   input  logic [15:0]              frame_len,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic                     underrun
);

   import fir_pkg::*;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fir_sample_streamer: DEPTH must be a power of two, at least 2");
   end
   if (TAPS < 2) begin : g_bad_taps
      $error("fir_sample_streamer: TAPS must be at least 2");
   end

   stream_state_t            r_state, w_state_nxt;
   logic [15:0]              r_remain, w_remain_nxt;
   logic                     r_out_vld, w_out_vld_nxt;
   logic signed [DATA_W-1:0] r_out_dat, w_out_dat_nxt;
   logic                     r_out_last, w_out_last_nxt;
   logic                     r_underrun, w_underrun_nxt;
   logic                     w_pop;
   logic                     w_fifo_empty;
   logic signed [DATA_W-1:0] w_fifo_head;
   logic                     w_xfer;
   logic                     w_slot;

   // Register is free to reload when it is empty or its beat leaves this cycle.
   assign w_xfer    = r_out_vld & out_ready;
   assign w_slot    = ~r_out_vld | w_xfer;
   assign out_valid = r_out_vld;
   assign out_data  = r_out_dat;
   assign out_last  = r_out_last;
   assign underrun  = r_underrun;
   assign busy      = (r_state != ST_IDLE);

   fir_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (w_pop),
      .rd_data (w_fifo_head),
      .empty   (w_fifo_empty),
      .full    (full),
      .count   (count)
   );

`ifdef FIR_SAMPLE_STREAMER_FLUSH_EN
   localparam int FCW = $clog2(TAPS + 1);
   localparam bit FLUSH_EN = 1'b1;
   logic [FCW-1:0] r_flush_cnt, w_flush_cnt_nxt;

   // Remaining trailing zeros; loaded on the STREAM to FLUSH hand-off.
   always_ff @(posedge clk) begin
      if (rst) r_flush_cnt <= '0;
      else     r_flush_cnt <= w_flush_cnt_nxt;
   end
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   // State and output register update; rst overrides start, writes and the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_remain   <= '0;
         r_out_vld  <= 1'b0;
         r_out_dat  <= '0;
         r_out_last <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_remain   <= w_remain_nxt;
         r_out_vld  <= w_out_vld_nxt;
         r_out_dat  <= w_out_dat_nxt;
         r_out_last <= w_out_last_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   // Next-state and output-register logic; frame end is only taken once the final beat has left.
   always_comb begin
      w_state_nxt    = r_state;
      w_remain_nxt   = r_remain;
      w_out_vld_nxt  = r_out_vld;
      w_out_dat_nxt  = r_out_dat;
      w_out_last_nxt = r_out_last;
      w_underrun_nxt = r_underrun;
      w_pop          = 1'b0;
`ifdef FIR_SAMPLE_STREAMER_FLUSH_EN
      w_flush_cnt_nxt = r_flush_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start && frame_len != 16'd0) begin
               w_state_nxt    = ST_STREAM;
               w_remain_nxt   = frame_len;
               w_underrun_nxt = 1'b0;
            end
         end
         ST_STREAM: begin
            if (w_slot) begin
               if (r_remain != 16'd0) begin
                  if (!w_fifo_empty) begin
                     w_pop          = 1'b1;
                     w_out_vld_nxt  = 1'b1;
                     w_out_dat_nxt  = w_fifo_head;
                     w_out_last_nxt = !FLUSH_EN && (r_remain == 16'd1);
                     w_remain_nxt   = r_remain - 16'd1;
                  end else begin
                     // Starved: leave a bubble rather than inventing a sample.
                     w_out_vld_nxt  = 1'b0;
                     w_underrun_nxt = 1'b1;
                  end
               end else begin
                  w_out_vld_nxt  = 1'b0;
                  w_out_last_nxt = 1'b0;
`ifdef FIR_SAMPLE_STREAMER_FLUSH_EN
                  w_state_nxt     = ST_FLUSH;
                  w_flush_cnt_nxt = FCW'(TAPS - 1);
`else
                  w_state_nxt     = ST_IDLE;
`endif
               end
            end
         end
`ifdef FIR_SAMPLE_STREAMER_FLUSH_EN
         ST_FLUSH: begin
            if (w_slot) begin
               if (r_flush_cnt != '0) begin
                  w_out_vld_nxt   = 1'b1;
                  w_out_dat_nxt   = '0;
                  w_out_last_nxt  = (r_flush_cnt == FCW'(1));
                  w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
               end else begin
                  w_out_vld_nxt  = 1'b0;
                  w_out_last_nxt = 1'b0;
                  w_state_nxt    = ST_IDLE;
               end
            end
         end
`endif
         default: begin
            w_state_nxt   = ST_IDLE;
            w_out_vld_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Directed self-checking bench for fir_sample_streamer with hand-computed frames.
// Latency: checks two-cycle first-beat latency and one-cycle return to idle.
// Backpressure: toggles out_ready and checks output stability during stalls.
module tb_fir_sample_streamer;

   import fir_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               wr_en = 1'b0;
   logic signed [15:0] wr_data = '0;
   logic               full;
   logic [6:0]         count;
   logic               start = 1'b0;
   logic [15:0]        frame_len = '0;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               out_ready = 1'b0;
   logic               out_last;
   logic               busy;
   logic               underrun;

   int n_checks = 0;
   int n_fails  = 0;

   sample_t beats[$];
   bit      lasts[$];
   sample_t exp_q[$];

   fir_sample_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .count     (count),
      .start     (start),
      .frame_len (frame_len),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int v);
      wr_en   = 1'b1;
      wr_data = 16'(v);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic do_start(input int len);
      start     = 1'b1;
      frame_len = 16'(len);
      tick();
      start     = 1'b0;
   endtask

   task automatic add_flush_zeros();
`ifdef FIR_SAMPLE_STREAMER_FLUSH_EN
      repeat (TAPS - 1) exp_q.push_back(16'sd0);
`endif
   endtask

   // Collects transferred beats until out_last, max_beats or max_cycles; checks stall stability.
   task automatic collect(input int max_beats, input int max_cycles, input bit toggle,
                          output int nb, output bit got_last);
      bit      stalled = 1'b0;
      sample_t held_dat = '0;
      bit      held_last = 1'b0;
      nb = 0;
      got_last = 1'b0;
      beats.delete();
      lasts.delete();
      for (int c = 0; c < max_cycles && !got_last && nb < max_beats; c++) begin
         out_ready = toggle ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_dat);
            check("stall_last", out_last, held_last);
         end
         stalled   = out_valid && !out_ready;
         held_dat  = out_data;
         held_last = out_last;
         if (out_valid && out_ready) begin
            beats.push_back(out_data);
            lasts.push_back(out_last);
            nb++;
            if (out_last) got_last = 1'b1;
         end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_nbeats"}, beats.size(), exp_q.size());
      n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_data"}, beats[i], exp_q[i]);
         check({tag, "_last"}, lasts[i], (i == exp_q.size() - 1));
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int nb;
      bit gl;
      int vcnt;
      int lcnt;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_underrun", underrun, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      tick();
      rst = 1'b0;
      tick();

      // Basic frame, latency and return to idle
      push(100); push(-200); push(300); push(-400); push(500);
      check("pre_count", count, 5);
      do_start(5);
      check("lat_t1_valid", out_valid, 0);
      check("lat_t1_busy", busy, 1);
      tick();
      check("lat_t2_valid", out_valid, 1);
      check("lat_t2_data", out_data, 100);
      collect(1000, 400, 1'b0, nb, gl);
      check("basic_got_last", gl, 1);
      exp_q = '{100, -200, 300, -400, 500};
      add_flush_zeros();
      compare_frame("basic");
      check("basic_idle_busy", busy, 0);
      check("basic_idle_valid", out_valid, 0);

      // Backpressure with toggling ready
      push(11); push(-22); push(33); push(-44); push(555); push(-666); push(7777); push(-8888);
      do_start(8);
      collect(1000, 800, 1'b1, nb, gl);
      check("bp_got_last", gl, 1);
      exp_q = '{11, -22, 33, -44, 555, -666, 7777, -8888};
      add_flush_zeros();
      compare_frame("bp");
      check("bp_count", count, 0);

      // Underrun mid-frame, then recovery
      push(-5); push(6);
      do_start(4);
      collect(1000, 8, 1'b0, nb, gl);
      check("ur_nbeats", nb, 2);
      check("ur_got_last", gl, 0);
      if (beats.size() == 2) begin
         check("ur_beat0", beats[0], -5);
         check("ur_beat1", beats[1], 6);
      end
      @(negedge clk);
      check("ur_valid", out_valid, 0);
      check("ur_flag", underrun, 1);
      check("ur_busy", busy, 1);
      tick();
      push(7); push(8);
      collect(1000, 400, 1'b0, nb, gl);
      exp_q = '{7, 8};
      add_flush_zeros();
      compare_frame("ur_tail");
      check("ur_sticky", underrun, 1);
      check("ur_idle_busy", busy, 0);

      // Fill past full, then stream the whole FIFO
      for (int i = 0; i < 65; i++) begin
         push(i * 517 - 16000);
         if (i == 63) begin
            check("full_at64", full, 1);
            check("count_at64", count, 64);
         end
      end
      check("full_after65", full, 1);
      check("count_after65", count, 64);
      do_start(64);
      check("ur_cleared", underrun, 0);
      collect(1000, 800, 1'b0, nb, gl);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(16'(i * 517 - 16000));
      add_flush_zeros();
      compare_frame("full_frame");
      check("full_frame_count", count, 0);

      // Reset mid-frame, with competing start and write in the same cycle
      for (int i = 0; i < 10; i++) push(1000 + i);
      do_start(10);
      collect(3, 50, 1'b0, nb, gl);
      check("mid_nbeats", nb, 3);
      rst = 1'b1; start = 1'b1; frame_len = 16'd5; wr_en = 1'b1; wr_data = 16'sd99;
      tick();
      rst = 1'b0; start = 1'b0; wr_en = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_last", out_last, 0);
      vcnt = 0;
      lcnt = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
         if (out_last) lcnt++;
         tick();
      end
      out_ready = 1'b0;
      check("post_rst_valid_beats", vcnt, 0);
      check("post_rst_last_beats", lcnt, 0);

      // start with frame_len=0 is ignored
      push(42);
      do_start(0);
      tick();
      check("zero_len_busy", busy, 0);
      check("zero_len_valid", out_valid, 0);
      check("zero_len_count", count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
